// File: rtl/alu_md_if.sv
// alu_md_if
// ---------------------------------------------------------------------------
// Bus bundle between the EX-stage controller and the alu_md block.
//   fun    : combinational ALU operation select (4 bits)
//   in1    : operand A, also the mthi/mtlo source
//   in2    : operand B
//   out    : combinational ALU result
//   md_op  : multiply/divide operation (0 mult, 1 multu, 2 div, 3 divu,
//            4 mthi, 5 mtlo, 6-7 none)
//   start  : request strobe for md_op, sampled on the rising clock edge
//   busy   : multiply/divide unit is running
//   hi, lo : architectural HI/LO registers
// Modports: master drives requests (controller / bench), slave is alu_md.
// ---------------------------------------------------------------------------
interface alu_md_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       fun;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic [2:0]       md_op;
    logic             start;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output fun, in1, in2, md_op, start,
        input  out, busy, hi, lo
    );

    modport slave (
        input  fun, in1, in2, md_op, start,
        output out, busy, hi, lo
    );
endinterface

// File: rtl/alu_md.sv
// alu_md
// ---------------------------------------------------------------------------
// EX-stage ALU with a multi-cycle multiply/divide unit and HI/LO registers.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : alu_md_if.slave (fun/in1/in2 -> out combinational ALU;
//           md_op/start -> busy/hi/lo multiply/divide unit)
// Parameters:
//   WIDTH   datapath width (>= 8)
//   MUL_LAT multiply busy cycles (>= 1)
//   DIV_LAT divide busy cycles (>= 1)
// Build option:
//   ALU_MD_DIV_EN  when defined, div/divu are implemented; when undefined no
//                  divider is built and md_op 2/3 are treated as no-ops.
// ---------------------------------------------------------------------------
module alu_md #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic     clk,
    input  logic     reset,
    alu_md_if.slave  bus
);
    localparam int SHW    = $clog2(WIDTH);
    localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
`ifdef ALU_MD_DIV_EN
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
`endif

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] lui_val;
    logic [SHW-1:0]   shamt;

    assign shamt = bus.in1[SHW-1:0];

    // lui places in2[15:0] at the top; narrow datapaths just pass in2 through.
    generate
        if (WIDTH > 16) begin : g_lui_wide
            assign lui_val = {bus.in2[15:0], {(WIDTH-16){1'b0}}};
        end else begin : g_lui_narrow
            assign lui_val = bus.in2;
        end
    endgenerate

    always_comb begin
        alu_out = '0;
        case (bus.fun)
            4'd0:    alu_out = bus.in1 + bus.in2;
            4'd1:    alu_out = bus.in1 - bus.in2;
            4'd2:    alu_out = bus.in1 | bus.in2;
            4'd3:    alu_out = {{(WIDTH-1){1'b0}}, (bus.in1 == bus.in2)};
            4'd4:    alu_out = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
            4'd5:    alu_out = lui_val;
            4'd6:    alu_out = bus.in1 & bus.in2;
            4'd7:    alu_out = bus.in1 ^ bus.in2;
            4'd8:    alu_out = ~(bus.in1 | bus.in2);
            4'd9:    alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
            4'd10:   alu_out = bus.in2 << shamt;
            4'd11:   alu_out = bus.in2 >> shamt;
            4'd12:   alu_out = $signed(bus.in2) >>> shamt;
            default: alu_out = '0;
        endcase
    end

    assign bus.out = alu_out;

    // ------------------------------------------------------------------
    // Multiply/divide unit state
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             sgn_q, sgn_d;
`ifdef ALU_MD_DIV_EN
    logic             div_q, div_d;
`endif

    // Operands are latched at acceptance, so the result depends only on the
    // captured values; it is committed on the final busy edge.
    logic [2*WIDTH-1:0] mul_a_ext;
    logic [2*WIDTH-1:0] mul_b_ext;
    logic [2*WIDTH-1:0] prod;

    assign mul_a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    assign mul_b_ext = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    // Sign-extended operands multiplied modulo 2^(2*WIDTH) give the
    // correct two's-complement product for both signed and unsigned.
    assign prod = mul_a_ext * mul_b_ext;

`ifdef ALU_MD_DIV_EN
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] abs_a, abs_b, divisor, uq, ur, quo, rem;

    assign a_neg   = sgn_q & a_q[WIDTH-1];
    assign b_neg   = sgn_q & b_q[WIDTH-1];
    assign abs_a   = a_neg ? -a_q : a_q;
    assign abs_b   = b_neg ? -b_q : b_q;
    assign b_zero  = (b_q == '0);
    // Divisor forced to 1 on zero so the divider never sees 0; the result
    // is discarded in that case anyway.
    assign divisor = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
    assign uq      = abs_a / divisor;
    assign ur      = abs_a % divisor;
    // Truncating division: quotient negative when signs differ, remainder
    // follows the dividend. Most-negative / -1 falls out naturally as
    // quotient = most-negative, remainder = 0.
    assign quo     = (a_neg ^ b_neg) ? -uq : uq;
    assign rem     = a_neg ? -ur : ur;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
`ifdef ALU_MD_DIV_EN
        div_d   = div_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.md_op)
                        3'd0, 3'd1: begin
                            a_d     = bus.in1;
                            b_d     = bus.in2;
                            sgn_d   = (bus.md_op == 3'd0);
`ifdef ALU_MD_DIV_EN
                            div_d   = 1'b0;
`endif
                            cnt_d   = MUL_CNT;
                            state_d = ST_RUN;
                        end
`ifdef ALU_MD_DIV_EN
                        3'd2, 3'd3: begin
                            a_d     = bus.in1;
                            b_d     = bus.in2;
                            sgn_d   = (bus.md_op == 3'd2);
                            div_d   = 1'b1;
                            cnt_d   = DIV_CNT;
                            state_d = ST_RUN;
                        end
`endif
                        3'd4:    hi_d = bus.in1;
                        3'd5:    lo_d = bus.in1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Requests arriving while running are dropped, not queued.
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef ALU_MD_DIV_EN
                    if (div_q) begin
                        if (!b_zero) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
`else
                    {hi_d, lo_d} = prod;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
`ifdef ALU_MD_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
`ifdef ALU_MD_DIV_EN
            div_q   <= div_d;
`endif
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md
// ---------------------------------------------------------------------------
// Bench for alu_md (WIDTH=32, MUL_LAT=5, DIV_LAT=10). Multiply/divide
// expectations are queued when a request is issued; a monitor pops and
// compares hi/lo and the busy length whenever busy falls. ALU and mthi/mtlo
// results are checked directly. Honours ALU_MD_DIV_EN like the design.
// ---------------------------------------------------------------------------
module tb_alu_md;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [7:0]   lat;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_md_if #(.WIDTH(W)) bus ();

    alu_md #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic alu_chk(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e);
        bus.fun = f;
        bus.in1 = a;
        bus.in2 = b;
        #1;
        chk($sformatf("alu fun=%0d a=%h b=%h", f, a, b), bus.out, e);
    endtask

    // Presents a request for one cycle, then scrambles the operands.
    task automatic md_start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.md_op = op;
        bus.in1   = a;
        bus.in2   = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.md_op = 3'd7;
        bus.in1   = 32'hDEAD_BEEF;
        bus.in2   = 32'h0BAD_F00D;
    endtask

    task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input int lat);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.lat = 8'(lat);
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still 1 after 40 cycles, required idle", name);
        end
    endtask

    // Monitor: counts busy cycles and scores each completed operation.
    initial begin
        bit   prev;
        int   n;
        exp_t e;
        prev = 1'b0;
        n    = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
                n    = 0;
            end else begin
                if (bus.busy) begin
                    n++;
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL md_unexpected: completion with hi=%h lo=%h, required none", bus.hi, bus.lo);
                    end else begin
                        e = sb.pop_front();
                        chk("md_hi", bus.hi, e.hi);
                        chk("md_lo", bus.lo, e.lo);
                        chk("md_busy_cycles", W'(n), W'(e.lat));
                    end
                    n = 0;
                end
                prev = bus.busy;
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [W-1:0] prev_lo;
        bit           done;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.fun   = 4'd0;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.md_op = 3'd7;
        bus.start = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", W'(bus.busy), '0);
        chk("reset_hi", bus.hi, '0);
        chk("reset_lo", bus.lo, '0);
        @(negedge clk);
        reset = 1'b0;

        // Combinational ALU
        alu_chk(4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        alu_chk(4'd1,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE);
        alu_chk(4'd2,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
        alu_chk(4'd3,  32'h0000_0005, 32'h0000_0005, 32'h0000_0001);
        alu_chk(4'd3,  32'h0000_0005, 32'h0000_0006, 32'h0000_0000);
        alu_chk(4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        alu_chk(4'd4,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
        alu_chk(4'd5,  32'h0000_0000, 32'h1234_ABCD, 32'hABCD_0000);
        alu_chk(4'd6,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        alu_chk(4'd7,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0);
        alu_chk(4'd8,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h000F_000F);
        alu_chk(4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        alu_chk(4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
        alu_chk(4'd10, 32'h0000_0024, 32'h8000_0001, 32'h0000_0010);
        alu_chk(4'd11, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000);
        alu_chk(4'd12, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000);
        alu_chk(4'd13, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
        alu_chk(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);

        // mthi / mtlo: immediate, no busy
        md_start(3'd4, 32'h0000_0012, 32'h0);
        chk("mthi_hi", bus.hi, 32'h12);
        chk("mthi_busy", W'(bus.busy), '0);
        md_start(3'd5, 32'h0000_0034, 32'h0);
        chk("mtlo_lo", bus.lo, 32'h34);
        chk("mtlo_hi_kept", bus.hi, 32'h12);

        // Multiplies (operands scrambled after acceptance by md_start)
        push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        md_start(3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
        chk("mult_hi_held_in_run", bus.hi, 32'h12);
        wait_idle("mult_wait");
        push(32'h0000_0001, 32'hFFFF_FFFE, 5);
        md_start(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle("multu_wait");

`ifdef ALU_MD_DIV_EN
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        md_start(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle("div_neg_wait");
        push(32'h0000_0001, 32'hFFFF_FFFD, 10);
        md_start(3'd2, 32'h0000_0007, 32'hFFFF_FFFE);
        wait_idle("div_negdivisor_wait");
        push(32'h0000_0000, 32'h8000_0000, 10);
        md_start(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf_wait");
        push(32'h0000_0000, 32'h8000_0000, 10);
        md_start(3'd3, 32'h0000_0005, 32'h0000_0000);
        wait_idle("divu_zero_wait");
        push(32'h0000_0002, 32'h0000_000E, 10);
        md_start(3'd3, 32'h0000_0064, 32'h0000_0007);
        wait_idle("divu_wait");
        prev_lo = 32'h0000_000E;
`else
        md_start(3'd4, 32'h0000_0012, 32'h0);
        md_start(3'd5, 32'h0000_0034, 32'h0);
        md_start(3'd2, 32'h0000_0064, 32'h0000_0007);
        chk("nodiv_div_busy", W'(bus.busy), '0);
        md_start(3'd3, 32'h0000_0064, 32'h0000_0007);
        for (int i = 0; i < 12; i++) @(negedge clk);
        chk("nodiv_busy_after", W'(bus.busy), '0);
        chk("nodiv_hi", bus.hi, 32'h12);
        chk("nodiv_lo", bus.lo, 32'h34);
        prev_lo = 32'h0000_0034;
`endif

        // Held start: mult, then mtlo 0x55 held through busy
        push(32'h0000_0000, 32'h0000_002A, 5);
        @(negedge clk);
        bus.md_op = 3'd0;
        bus.in1   = 32'd6;
        bus.in2   = 32'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.md_op = 3'd5;
        bus.in1   = 32'h0000_0055;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.busy) chk("held_lo_during_busy", bus.lo, prev_lo);
            else          done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL held_wait: busy still 1 after 20 cycles, required idle");
        end
        @(posedge clk);
        #1;
        chk("held_next_cycle_lo", bus.lo, 32'h55);
        chk("held_next_cycle_busy", W'(bus.busy), '0);
        chk("held_next_cycle_hi", bus.hi, 32'h0);
        bus.start = 1'b0;
        bus.md_op = 3'd7;

        // Reset in the 3rd busy cycle of a mult (no expectation queued)
        md_start(3'd0, 32'd9, 32'd9);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", W'(bus.busy), '0);
        chk("abort_hi", bus.hi, '0);
        chk("abort_lo", bus.lo, '0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("abort_late_busy", W'(bus.busy), '0);
        chk("abort_late_hi", bus.hi, '0);
        chk("abort_late_lo", bus.lo, '0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", W'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
